// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand classes, bias/NaN constants and flag bit positions.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic longint unsigned fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand decode: sign, class and mantissa with the hidden bit restored.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int DW = 1 + EXP_W + MAN_W
) (
  input  logic [DW-1:0]  op_i,
  output logic           sign_o,
  output fp_class_e      cls_o,
  output logic [MAN_W:0] man_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;

  assign sign_o = op_i[DW-1];
  assign exp_f  = op_i[DW-2 -: EXP_W];
  assign frac_f = op_i[MAN_W-1:0];

  // Subnormals are flushed: a zero exponent always classifies as zero.
  always_comb begin
    cls_o = FP_NORM;
    man_o = {1'b1, frac_f};
    if (exp_f == '0) begin
      cls_o = FP_ZERO;
      man_o = '0;
    end else if (&exp_f) begin
      man_o = '0;
      if (frac_f == '0) cls_o = FP_INF;
      else              cls_o = FP_NAN;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Five-stage handshaked FP multiplier with RNE rounding and zero/inf/NaN handling.
// Define FP_MULT_FLAGS_EN to add the flags_o port {invalid, overflow, underflow, inexact}.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int DW = 1 + EXP_W + MAN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] c_o
`ifdef FP_MULT_FLAGS_EN
  ,
  output logic [3:0]    flags_o
`endif
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] ZERO = EW'(0);
  localparam logic [DW-1:0]        QNAN = DW'(fp_qnan(EXP_W, MAN_W));

  logic advance;
  logic [3:0] v_q;

  logic           sgn_a, sgn_b;
  fp_class_e      cls_a, cls_b;
  logic [MAN_W:0] man_a, man_b;

  fp_class_e              kind_d;
  logic signed [EW-1:0]   exp_sum_d;
  logic                   s1_sign_q, s2_sign_q, s3_sign_q, s4_sign_q;
  fp_class_e              s1_kind_q, s2_kind_q, s3_kind_q, s4_kind_q;
  logic signed [EW-1:0]   s1_exp_q, s2_exp_q, s3_exp_q, s4_exp_q;
  logic [MAN_W:0]         s1_ma_q, s1_mb_q;
  logic [PW-1:0]          s2_prod_q;
  logic [MAN_W:0]         s3_man_q, s3_man_d;
  logic                   s3_g_q, s3_r_q, s3_s_q, s3_g_d, s3_r_d, s3_s_d;
  logic signed [EW-1:0]   s3_exp_d, s4_exp_d;
  logic [MAN_W-1:0]       s4_frac_q, s4_frac_d;
  logic [MAN_W+1:0]       man_r;
  logic                   round_up, ovf, unf;
  logic [DW-1:0]          c_d;

  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op_i(a_i), .sign_o(sgn_a), .cls_o(cls_a), .man_o(man_a)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op_i(b_i), .sign_o(sgn_b), .cls_o(cls_b), .man_o(man_b)
  );

  assign exp_sum_d = $signed({2'b00, a_i[DW-2 -: EXP_W]})
                   + $signed({2'b00, b_i[DW-2 -: EXP_W]}) - BIAS;

  always_comb begin
    kind_d = FP_NORM;
    if (cls_a == FP_NAN || cls_b == FP_NAN ||
        (cls_a == FP_INF && cls_b == FP_ZERO) || (cls_a == FP_ZERO && cls_b == FP_INF))
      kind_d = FP_NAN;
    else if (cls_a == FP_INF || cls_b == FP_INF)
      kind_d = FP_INF;
    else if (cls_a == FP_ZERO || cls_b == FP_ZERO)
      kind_d = FP_ZERO;
  end

  // Product lies in [1,4); the top bit selects which window holds the kept mantissa.
  always_comb begin
    s3_exp_d = s2_exp_q;
    s3_man_d = s2_prod_q[PW-2 -: MAN_W+1];
    s3_g_d   = s2_prod_q[MAN_W-1];
    s3_r_d   = s2_prod_q[MAN_W-2];
    s3_s_d   = |s2_prod_q[MAN_W-3:0];
    if (s2_prod_q[PW-1]) begin
      s3_exp_d = s2_exp_q + ONE;
      s3_man_d = s2_prod_q[PW-1 -: MAN_W+1];
      s3_g_d   = s2_prod_q[MAN_W];
      s3_r_d   = s2_prod_q[MAN_W-1];
      s3_s_d   = |s2_prod_q[MAN_W-2:0];
    end
  end

  assign round_up = s3_g_q & (s3_r_q | s3_s_q | s3_man_q[0]);
  assign man_r    = {1'b0, s3_man_q} + (MAN_W+2)'(round_up);

  always_comb begin
    s4_exp_d  = s3_exp_q;
    s4_frac_d = man_r[MAN_W-1:0];
    if (man_r[MAN_W+1]) begin
      s4_exp_d  = s3_exp_q + ONE;
      s4_frac_d = man_r[MAN_W:1];
    end
  end

  assign ovf = (s4_exp_q >= EMAX);
  assign unf = (s4_exp_q <= ZERO);

  always_comb begin
    c_d = {s4_sign_q, s4_exp_q[EXP_W-1:0], s4_frac_q};
    case (s4_kind_q)
      FP_NAN:  c_d = QNAN;
      FP_INF:  c_d = {s4_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FP_ZERO: c_d = {s4_sign_q, {(DW-1){1'b0}}};
      default: begin
        if (ovf)      c_d = {s4_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (unf) c_d = {s4_sign_q, {(DW-1){1'b0}}};
      end
    endcase
  end

`ifdef FP_MULT_FLAGS_EN
  logic       s4_inx_q;
  logic [3:0] flags_d;

  always_comb begin
    flags_d          = '0;
    flags_d[FLG_INV] = (s4_kind_q == FP_NAN);
    if (s4_kind_q == FP_NORM) begin
      flags_d[FLG_OVF] = ovf;
      flags_d[FLG_UNF] = unf;
      flags_d[FLG_INX] = s4_inx_q | ovf | unf;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) s4_inx_q <= s3_g_q | s3_r_q | s3_s_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      out_valid <= 1'b0;
      c_o       <= '0;
`ifdef FP_MULT_FLAGS_EN
      flags_o   <= '0;
`endif
    end else if (advance) begin
      v_q       <= {v_q[2:0], in_valid};
      out_valid <= v_q[3];
      c_o       <= c_d;
`ifdef FP_MULT_FLAGS_EN
      flags_o   <= flags_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign_q <= sgn_a ^ sgn_b;
      s1_kind_q <= kind_d;
      s1_exp_q  <= exp_sum_d;
      s1_ma_q   <= man_a;
      s1_mb_q   <= man_b;
      s2_sign_q <= s1_sign_q;
      s2_kind_q <= s1_kind_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= PW'(s1_ma_q) * PW'(s1_mb_q);
      s3_sign_q <= s2_sign_q;
      s3_kind_q <= s2_kind_q;
      s3_exp_q  <= s3_exp_d;
      s3_man_q  <= s3_man_d;
      s3_g_q    <= s3_g_d;
      s3_r_q    <= s3_r_d;
      s3_s_q    <= s3_s_d;
      s4_sign_q <= s3_sign_q;
      s4_kind_q <= s3_kind_q;
      s4_exp_q  <= s4_exp_d;
      s4_frac_q <= s4_frac_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: known products, back-pressure ordering and mid-flight reset.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] c_o;
`ifdef FP_MULT_FLAGS_EN
  logic [3:0]  flags_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] bp_exp [20];
  logic [31:0] held;
  logic        acc, stalled;
  int          got, cyc, stale, guard;

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_i(a_i),
    .b_i(b_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c_o(c_o)
`ifdef FP_MULT_FLAGS_EN
    ,
    .flags_o(flags_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_c, input logic [3:0] exp_f);
    a_i = a;
    b_i = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, c_o, exp_c);
`ifdef FP_MULT_FLAGS_EN
    chk({tag, "_flags"}, 32'(flags_o), 32'(exp_f));
`endif
    $display("vec %s: a=%h b=%h c=%h expect=%h flags_expect=%b", tag, a, b, c_o, exp_c, exp_f);
    step();
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c_o", c_o, 32'd0);
`ifdef FP_MULT_FLAGS_EN
    chk("rst_flags", 32'(flags_o), 32'd0);
`endif
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed products: flags {inv, ovf, unf, inx}
    vec("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    vec("tie_even",    32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
    vec("overflow",    32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    vec("underflow",   32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    vec("inf_x_zero",  32'hFF800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    vec("nan_in",      32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000);
    vec("neg_x_pos",   32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
    vec("neg_inf",     32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);

    // Back-pressure: 20 beats, x*2.0 only bumps the exponent
    for (int k = 0; k < 20; k++) bp_exp[k] = (32'h3F800000 | (32'(k) << 16)) + 32'h00800000;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          a_i = 32'h3F800000 | (32'(k) << 16);
          b_i = 32'h40000000;
          in_valid = 1'b1;
          guard = 0;
          do begin
            @(negedge clk);
            acc = in_ready;
            step();
            guard++;
          end while (!acc && guard < 200);
        end
        in_valid = 1'b0;
      end
      begin
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        while (got < 20 && cyc < 600) begin
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (stalled) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", c_o, held);
          end
          stalled = 1'b0;
          if (out_valid) begin
            if (out_ready) begin
              chk("bp_data", c_o, bp_exp[got]);
              $display("bp beat %0d: c=%h expect=%h", got, c_o, bp_exp[got]);
              got++;
            end else begin
              stalled = 1'b1;
              held = c_o;
            end
          end
          step();
          cyc++;
        end
        chk("bp_count", 32'(got), 32'd20);
      end
    join
    out_ready = 1'b1;
    repeat (8) step();
    chk("bp_no_extra", 32'(out_valid), 32'd0);

    // Reset with three beats in flight, oldest stalled at the output
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_i = 32'h40000000 + 32'(k);
      b_i = 32'h40000000;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_c_o", c_o, 32'd0);
    $display("reset asserted with 3 beats in flight: out_valid=%b", out_valid);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid) stale++;
    end
    chk("no_stale", 32'(stale), 32'd0);
    vec("after_rst", 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
